dir_input_queue: RTL
====================

# dir_input_queue

Multi-player, debounced, buffered direction input stage for the snake game. It turns raw up/down/left/right buttons into one-hot direction events and filters out illegal turns. Legal turns are queued per player, and the queue is drained one entry per game tick. It sits between the board pins and the movement logic, and replaces single-latch direction capture so that fast turn sequences between ticks are not lost.

## Interface
- N_PLAYERS, 1: number of independent direction channels (1..4).
- QUEUE_DEPTH, 4: turn entries buffered per player; power of two, 2..16.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles needed to change a debounced level; at least 1.
- DIR_RESET, 4'b0001: one-hot direction loaded into every channel at reset.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn  in  4*N_PLAYERS  raw buttons, asynchronous. Per player p, bits [4p+3:4p] are {right, left, down, up}.
- enable  in  1  high: presses may be queued; low: presses are discarded.
- tick  in  1  one-cycle game-step pulse; pops one entry per non-empty queue.
- clr_ovf  in  1  clears all overflow flags.
- dir  out  4*N_PLAYERS  current one-hot direction per player. Encoding: bit0 up, bit1 down, bit2 left, bit3 right.
- q_count  out  N_PLAYERS*$clog2(QUEUE_DEPTH+1)  occupancy per player.
- ovf  out  N_PLAYERS  sticky flag: a legal press was dropped because the queue was full.

## Operation
- Per button:
  - 2-flop synchronizer feeds a debouncer (counter plus debounced level `db`).
  - While sync ≠ db, the counter increments; when sync = db, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync still ≠ db, db toggles on that edge and the counter clears.
- Press event: db & ~db_q, where db_q is db delayed one cycle. Events are evaluated combinationally and take effect at the next edge.
- Multiple simultaneous events for one player: the lowest bit wins (up > down > left > right); the others are discarded.
- Reference direction `ref`:
  - queue non-empty: the tail entry (most recently queued);
  - queue empty: `dir`.
- Legality: the event is dropped when it equals `ref` (duplicate) or is the opposite of `ref` (up/down, left/right).
- Push: legal event, enable = 1, queue not full → write at the tail, increment occupancy.
- Overflow: legal event, enable = 1, queue full → drop the event and set ovf[p].
- Pop: tick = 1 and queue non-empty → dir[p] <= head entry, head advances, occupancy decrements.
- tick with an empty queue: dir is held.
- Simultaneous push and pop in one cycle:
  - both occur; occupancy is unchanged;
  - legality is checked against the pre-edge `ref`;
  - on a full queue the push succeeds, because the pop frees a slot in the same edge.
- Empty queue with push and tick in the same cycle: the entry is queued; dir changes on the next tick, not this one.
- enable low: debouncers and edge detection keep running; events in those cycles are lost (not deferred); pops still happen.
- ovf: set has priority over a simultaneous clr_ovf.
- Channels are fully independent; no state is shared except clk, rst, enable, tick and clr_ovf.
- Queue pointers are $clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH. Occupancy is a separate counter from 0 to QUEUE_DEPTH.

## Timing
- Reset values: dir = DIR_RESET in every channel; q_count = 0; ovf = 0; queues empty; synchronizers, db, db_q and counters all 0.
- rst asserted mid-operation: the next edge applies the full reset. Queued entries are discarded and held buttons must be debounced again. A button still held through reset produces a fresh event once its db rises after reset.
- Press latency: raw 0→1 sampled at edge E0 → sync high after edge E1 → db high after edge E1+DEBOUNCE_CYCLES → queue write at edge E2+DEBOUNCE_CYCLES. q_count is visible one edge after the event cycle.
- Pop latency: tick high in cycle T → dir and q_count update at the end of T (visible in T+1).
- Release, and glitches shorter than DEBOUNCE_CYCLES synchronized cycles, produce no event.
- Throughput: at most one push and one pop per player per cycle.

## Test plan
- Reset, N_PLAYERS=1, DEBOUNCE_CYCLES=4: dir=0001, q_count=0, ovf=0. Hold right → q_count=1 exactly 6 edges after the first sampled high; tick → dir=1000, q_count=0.
- Reversal and duplicate filter: dir=0001, press down then up → q_count stays 0. Press left, then right → only left is queued (q_count=1).
- Turn sequence: press left, then down (separately debounced), no tick → q_count=2. Tick twice → dir 0100 then 0010; a third tick holds 0010.
- Overflow, QUEUE_DEPTH=4: fill with alternating legal turns to 4, a fifth legal press → dropped, ovf=1. clr_ovf → ovf=0. Full queue with legal push and tick in the same cycle → q_count stays 4, ovf stays 0.
- Glitch and enable: a 3-cycle pulse on up with DEBOUNCE_CYCLES=4 → no event. A press while enable=0 → no entry, and no event after enable rises while the button is still held.
- Multi-player, N_PLAYERS=2: player0 left and player1 right pressed in the same cycle; tick → dir = {1000, 0100}. rst mid-queue → both channels return to 0001 with q_count=0.

Source files
------------

// File: rtl/dir_input_queue.sv
// Debounced, per-player direction input stage: buttons -> one-hot press events ->
// legality filter -> small FIFO of pending turns, drained one entry per game tick.
module dir_input_queue #(
  parameter int         N_PLAYERS       = 1,
  parameter int         QUEUE_DEPTH     = 4,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [3:0] DIR_RESET       = 4'b0001
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [4*N_PLAYERS-1:0]                       btn,
  input  logic                                         enable,
  input  logic                                         tick,
  input  logic                                         clr_ovf,
  output logic [4*N_PLAYERS-1:0]                       dir,
  output logic [N_PLAYERS*$clog2(QUEUE_DEPTH+1)-1:0]   q_count,
  output logic [N_PLAYERS-1:0]                         ovf
);

  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int NB  = 4 * N_PLAYERS;

  logic [NB-1:0]  sync1;
  logic [NB-1:0]  sync2;
  logic [NB-1:0]  db;
  logic [NB-1:0]  db_q;
  logic [NB-1:0]  press;
  logic [DBW-1:0] db_cnt [NB];

  // The counter only runs while the synchronized level disagrees with db, so any
  // agreement (glitch ending) restarts the stability window from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_q;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [3:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [3:0]    cur_dir;
    logic          ovf_r;
    logic [3:0]    pv;
    logic [3:0]    ev;
    logic [3:0]    ref_dir;
    logic [3:0]    opp_dir;
    logic          legal;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;

    assign pv = press[4*p +: 4];

    always_comb begin
      ev = 4'b0000;
      if (pv[0])      ev = 4'b0001;
      else if (pv[1]) ev = 4'b0010;
      else if (pv[2]) ev = 4'b0100;
      else if (pv[3]) ev = 4'b1000;
    end

    // A turn is judged against where the snake will be heading once everything
    // already queued has been applied, i.e. the newest queued entry.
    assign ref_dir = (count != '0) ? mem[tail - PW'(1)] : cur_dir;
    assign opp_dir = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
    assign legal   = (ev != 4'b0000) && (ev != ref_dir) && (ev != opp_dir);
    assign full    = (count == CW'(QUEUE_DEPTH));
    assign do_pop  = tick && (count != '0);
    assign do_push = legal && enable && (!full || do_pop);
    assign ovf_set = legal && enable && full && !do_pop;

    always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= ev;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        cur_dir <= DIR_RESET;
        ovf_r   <= 1'b0;
      end else begin
        if (do_push) tail <= tail + PW'(1);
        if (do_pop) begin
          head    <= head + PW'(1);
          cur_dir <= mem[head];
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (ovf_set)      ovf_r <= 1'b1;
        else if (clr_ovf) ovf_r <= 1'b0;
      end
    end

    assign dir[4*p +: 4]      = cur_dir;
    assign q_count[CW*p +: CW] = count;
    assign ovf[p]             = ovf_r;
  end

endmodule
